// File: rtl/counter_display_if.sv
// counter_display_if: counter value in, BCD and multiplexed 7-segment drive out.
interface counter_display_if;
  logic [7:0]  value_in;
  logic        busy;
  logic [11:0] bcd_out;
  logic [6:0]  seg;
  logic [2:0]  an;
  modport master (output value_in, input busy, bcd_out, seg, an);
  modport slave  (input value_in, output busy, bcd_out, seg, an);
endinterface

// File: rtl/counter_display_driver.sv
// counter_display_driver: shift-add-3 binary-to-BCD converter feeding a 3-digit
// multiplexed common-anode 7-segment display with optional leading-zero blanking.
module counter_display_driver #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1
) (
  input logic clk,
  input logic reset,
  counter_display_if.slave disp
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [15:0] PMAX = 16'(SCAN_DIV - 1);
  state_t      state_q, state_d;
  logic [7:0]  last_q, last_d, shift_q, shift_d;
  logic [9:0]  scr_q, scr_d, adj;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic [15:0] pre_q, pre_d;
  logic [1:0]  sel_q, sel_d;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  an_q, an_d;
  logic [3:0]  dig;
  logic        blank;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction
  // Hundreds holds at most 2, so only the two lower nibbles ever need the +3 fix-up
  always_comb begin
    adj[3:0] = scr_q[3:0] >= 4'd5 ? scr_q[3:0] + 4'd3 : scr_q[3:0];
    adj[7:4] = scr_q[7:4] >= 4'd5 ? scr_q[7:4] + 4'd3 : scr_q[7:4];
    adj[9:8] = scr_q[9:8];
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (disp.value_in != last_q) begin
        last_d  = disp.value_in;
        shift_d = disp.value_in;
        scr_d   = '0;
        iter_d  = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {scr_d, shift_d} = {adj[8:0], shift_q, 1'b0};
        iter_d  = iter_q + 3'd1;
        state_d = iter_q == 3'd7 ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = {2'b00, scr_q};
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pre_d = pre_q == PMAX ? '0 : pre_q + 16'd1;
    sel_d = pre_q == PMAX ? (sel_q >= 2'd2 ? 2'd0 : sel_q + 2'd1) : (sel_q == 2'd3 ? 2'd0 : sel_q);
    dig   = sel_q == 2'd0 ? bcd_q[3:0] : sel_q == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
    blank = BLANK_LZ && bcd_q[11:8] == 4'd0 && (sel_q == 2'd2 || (sel_q == 2'd1 && bcd_q[7:4] == 4'd0));
    seg_d = blank ? 7'h7F : seg7(dig);
    an_d  = sel_q == 2'd0 ? 3'b110 : sel_q == 2'd1 ? 3'b101 : sel_q == 2'd2 ? 3'b011 : 3'b111;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      pre_q   <= '0;
      sel_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= 3'b111;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end
  assign disp.busy    = busy_q;
  assign disp.bcd_out = bcd_q;
  assign disp.seg     = seg_q;
  assign disp.an      = an_q;
endmodule

// File: tb/tb_counter_display_driver.sv
// tb_counter_display_driver: two instances (blanking on/off) checked against a
// cycle-counting decimal model plus directed latency, skip and reset sequences.
module tb_counter_display_driver;
  localparam int SD = 4;
  logic clk = 1'b0, reset = 1'b0, mon = 1'b0;
  logic [7:0] val = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  counter_display_if if1 ();
  counter_display_if if0 ();
  assign if1.value_in = val;
  assign if0.value_in = val;
  counter_display_driver #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut1 (.clk(clk), .reset(reset), .disp(if1.slave));
  counter_display_driver #(.SCAN_DIV(SD), .BLANK_LZ(0)) dut0 (.clk(clk), .reset(reset), .disp(if0.slave));
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] segc(input logic [3:0] d);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return d > 4'd9 ? 7'h7F : t[d];
  endfunction
  function automatic logic [11:0] dec(input logic [7:0] v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  // Reference model: edge count drives the scan, a countdown stands in for the converter
  int m_n, m_cnt, m_s;
  logic [7:0] m_last;
  logic [11:0] m_bcd;
  logic m_busy;
  logic [6:0] m_seg1, m_seg0;
  logic [2:0] m_an;
  logic [3:0] m_d;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_n = 0; m_cnt = 0; m_last = '0; m_bcd = '0; m_busy = 1'b0;
      m_seg1 = 7'h7F; m_seg0 = 7'h7F; m_an = 3'b111;
    end else begin
      m_s = (m_n / SD) % 3;
      m_d = m_s == 0 ? m_bcd[3:0] : m_s == 1 ? m_bcd[7:4] : m_bcd[11:8];
      m_an = m_s == 0 ? 3'b110 : m_s == 1 ? 3'b101 : 3'b011;
      m_seg0 = segc(m_d);
      m_seg1 = ((m_s == 2 && m_bcd[11:8] == 0) || (m_s == 1 && m_bcd[11:4] == 0)) ? 7'h7F : segc(m_d);
      m_n++;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_bcd = dec(m_last);
          m_busy = 1'b0;
        end
      end else if (val != m_last) begin
        m_last = val;
        m_cnt = 9;
        m_busy = 1'b1;
      end
    end
  end
  always @(negedge clk) if (mon && reset) begin
    chk("mdl_busy", if1.busy, m_busy);
    chk("mdl_bcd", if1.bcd_out, m_bcd);
    chk("mdl_seg_blank", if1.seg, m_seg1);
    chk("mdl_an", if1.an, m_an);
    chk("mdl_busy_nb", if0.busy, m_busy);
    chk("mdl_bcd_nb", if0.bcd_out, m_bcd);
    chk("mdl_seg_noblank", if0.seg, m_seg0);
    chk("mdl_an_nb", if0.an, m_an);
  end
  task automatic conv(input logic [7:0] v, input logic [11:0] exp);
    logic [11:0] old;
    @(negedge clk);
    old = if1.bcd_out;
    val = v;
    @(negedge clk);
    chk("lat_busy_rise", if1.busy, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("lat_busy_hold", if1.busy, 1'b1);
      chk("lat_bcd_hold", if1.bcd_out, old);
    end
    @(negedge clk);
    chk("lat_busy_fall", if1.busy, 1'b0);
    chk("lat_bcd", if1.bcd_out, exp);
    chk("lat_bcd_nb", if0.bcd_out, exp);
  endtask
  task automatic digit_check(input logic [6:0] h1, t1, o1, h0, t0, o0);
    for (int i = 0; i < 3 * SD; i++) begin
      @(negedge clk);
      if (if1.an == 3'b110) begin
        chk("dig_ones", if1.seg, o1); chk("dig_ones_nb", if0.seg, o0);
      end else if (if1.an == 3'b101) begin
        chk("dig_tens", if1.seg, t1); chk("dig_tens_nb", if0.seg, t0);
      end else begin
        chk("dig_hund_an", if1.an, 3'b011);
        chk("dig_hund", if1.seg, h1); chk("dig_hund_nb", if0.seg, h0);
      end
    end
  endtask
  typedef struct {logic [7:0] v; logic [11:0] e;} vec_t;
  vec_t vecs [7];
  initial begin
    logic [11:0] b, old;
    bit seen;
    vecs = '{'{8'd0, 12'h000}, '{8'd9, 12'h009}, '{8'd10, 12'h010}, '{8'd99, 12'h099},
             '{8'd100, 12'h100}, '{8'd199, 12'h199}, '{8'd250, 12'h250}};
    repeat (3) @(negedge clk);
    chk("rst_busy", if1.busy, 1'b0);
    chk("rst_bcd", if1.bcd_out, 12'h000);
    chk("rst_seg", if1.seg, 7'h7F);
    chk("rst_an", if1.an, 3'b111);
    reset = 1'b1;
    mon = 1'b1;
    digit_check(7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);
    conv(8'd255, 12'h255);
    digit_check(7'h24, 7'h12, 7'h12, 7'h24, 7'h12, 7'h12);
    conv(8'd7, 12'h007);
    digit_check(7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40, 7'h78);
    for (int i = 0; i < 7; i++) conv(vecs[i].v, vecs[i].e);
    @(negedge clk);
    old = if1.bcd_out;
    val = 8'd100;
    repeat (3) @(negedge clk);
    val = 8'd42;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      b = if1.bcd_out;
      if (b == 12'h100) seen = 1'b1;
      chk("skip_no_intermediate", (b == old || b == 12'h100 || b == 12'h042), 1'b1);
    end
    chk("skip_first_seen", seen, 1'b1);
    chk("skip_final", if1.bcd_out, 12'h042);
    conv(8'd128, 12'h128);
    digit_check(7'h79, 7'h24, 7'h00, 7'h79, 7'h24, 7'h00);
    @(negedge clk);
    val = 8'd200;
    @(negedge clk);
    chk("rst_mid_busy_pre", if1.busy, 1'b1);
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_busy", if1.busy, 1'b0);
    chk("rst_mid_bcd", if1.bcd_out, 12'h000);
    chk("rst_mid_seg", if1.seg, 7'h7F);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_capture", if1.busy, 1'b1);
    repeat (8) @(negedge clk);
    chk("rel_bcd_pending", if1.bcd_out, 12'h000);
    @(negedge clk);
    chk("rel_bcd", if1.bcd_out, 12'h200);
    chk("rel_busy", if1.busy, 1'b0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) val = 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    repeat (12) @(negedge clk);
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/counter_display_driver.md
Name: counter_display_driver

Overview:
- Downstream consumer of the 8-bit up/down counter value (counter_out), driving a 3-digit multiplexed common-anode 7-segment display.
- Converts the binary value to BCD using an iterative shift-add-3 FSM, one bit per cycle.
- Holds the result in display registers and time-multiplexes the three digits.
- Optionally blanks leading zeros.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays lit; legal range 2..65535.
- BLANK_LZ, 1: 1 = blank leading zeros (hundreds, then tens); 0 = always show 3 digits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- value_in  input  8  binary value from the counter; synchronous to clk.
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  12  display registers {hundreds, tens, ones}, 4 bits each.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  output  3  digit enables {hundreds, tens, ones}, active-low, one-hot.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_val=0, bcd_out=12'h000, busy=0, prescaler=0, digit_sel=0, seg=7'h7F, an=3'b111.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - At each edge, if value_in != last_val: latch last_val<=value_in and shift_reg<=value_in; clear the scratch BCD; iter<=0; busy<=1; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Add 3 to every scratch BCD nibble >=5.
  - Shift {scratch, shift_reg} left by 1.
  - iter<=iter+1.
  - After the 8th SHIFT cycle (iter==7 at the edge), go to DONE.
- DONE:
  - bcd_out <= scratch (all three digits atomically).
  - busy<=0; go to IDLE.
- Latency:
  - A change is captured at edge E.
  - bcd_out is updated at edge E+9 and busy falls at E+9.
  - A new change can be captured at edge E+10 at the earliest.
- value_in changes while busy are ignored. IDLE re-compares against last_val, so the final stable value is always converted. Intermediate values may be skipped.
- Scratch width is 10 bits (max 255 -> 2/5/5). The hundreds nibble upper bits stay 0.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, digit_sel advances 0->1->2->0.
  - digit_sel: 0 = ones, 1 = tens, 2 = hundreds. The value 3 is never reached; if it occurs, force it to 0.
- Output register (seg, an):
  - Loaded every edge from the current digit_sel and bcd_out, i.e. one cycle behind digit_sel.
  - an: ones = 3'b110, tens = 3'b101, hundreds = 3'b011.
- Segment codes, active-low gfedcba:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Any nibble >9 gives 7'h7F.
- Blanking with BLANK_LZ=1:
  - Hundreds is blank when hundreds==0.
  - Tens is blank when hundreds==0 && tens==0.
  - Ones is never blank.
  - For a blanked digit, seg=7'h7F and its an bit is still driven active (anode timing unchanged).
- Reset mid-conversion: abort immediately, with all registers set to their reset values. After release, a nonzero value_in is captured on the first edge.
- bcd_out is never partially updated; it changes only in DONE.

Test Plan:
1. Reset, value_in=0 held -> busy stays 0; bcd_out=12'h000; with BLANK_LZ=1 only ones shows 7'h40, hundreds/tens show 7'h7F.
2. value_in 0->255 at edge E -> busy=1 from E, bcd_out=12'h255 and busy=0 at E+9; digits show 7'h24, 7'h12, 7'h12.
3. value_in=7, BLANK_LZ=1 -> bcd_out=12'h007; hundreds and tens seg=7'h7F, ones 7'h78. Same value with BLANK_LZ=0 -> 7'h40, 7'h40, 7'h78.
4. value_in 100 then 42 three cycles later (while busy) -> first bcd_out=12'h100, then a second conversion with bcd_out=12'h042; no other intermediate values appear.
5. SCAN_DIV=4, steady value 128 -> an cycles 110 (4 cycles), 101 (4), 011 (4), repeating; seg matches 8, 2, 1 respectively, one cycle after the digit_sel change.
6. Assert reset 4 cycles into a conversion of 200 -> bcd_out=0 and busy=0 immediately. After release with 200 held -> bcd_out=12'h200 nine edges after the capture edge.
